datapath_ctrl: RTL and testbench
================================

// Module: datapath_ctrl
// PURPOSE
//  Upstream sequencer for the 4x16 register-file/ALU datapath. Accepts a command
//  (op, dst, src, iter) with a start/done handshake, then drives the datapath strobes
//  rsel/w/Rw/Rr/loadA/aluop/loadN. It consumes the datapath's registered N flag to
//  branch during shift-compare steps. It is the only driver of the datapath control inputs.
// PARAMETERS
//  ITER_W   4   width of iter input and internal step counter
// PORTS
//  clk     in   1       rising-edge clock, shared with datapath
//  reset   in   1       synchronous, active-high
//  start   in   1       command valid; sampled only in S_IDLE
//  op      in   2       00 LOAD, 01 SHL, 10 PACK, 11 STEP
//  dst     in   2       destination register index
//  src     in   2       source register index
//  iter    in   ITER_W  STEP repeat count
//  N       in   1       datapath flag (1 = last ALU result non-negative)
//  rsel    out  1       0 = write `in`, 1 = write ALU result
//  w       out  1       register-file write enable
//  Rw      out  2       write index
//  Rr      out  2       read index
//  loadA   out  1       load A from R[Rr]
//  aluop   out  2       00 <<1, 01 <<1|1, 10 pack, 11 A.hi - R
//  loadN   out  1       capture N
//  busy    out  1       high in every state except S_IDLE
//  done    out  1       1-cycle pulse at command completion
//  err     out  1       sticky protocol error (see CONFIGURATION)
// BEHAVIOUR
//  - Moore FSM. State is registered. Outputs are decoded from state plus latched dst/src.
//  - On start in S_IDLE, latch op/dst/src/iter. start outside S_IDLE is ignored.
//  - States: S_IDLE, S_WR, S_LDA, S_PACK, S_CMP, S_STEP, S_DONE.
//  - Transitions out of S_IDLE on start:
//    - LOAD -> S_WR: rsel=0, w=1, Rw=dst.
//    - SHL  -> S_WR: rsel=1, w=1, Rw=dst, Rr=src, aluop=00.
//    - PACK -> S_LDA (loadA=1, Rr=src) -> S_PACK (Rr=dst, aluop=10, rsel=1, w=1, Rw=dst).
//    - STEP -> S_LDA -> S_CMP (Rr=dst, aluop=11, loadN=1, w=0) -> S_STEP (Rr=dst, Rw=dst,
//      rsel=1, w=1, aluop = N ? 01 : 00). Counter decrements in S_STEP.
//      Go back to S_CMP while count != 0, else S_DONE.
//  - S_WR and S_PACK -> S_DONE. S_DONE asserts done=1 -> S_IDLE.
//  - Latency from start edge to done high: LOAD/SHL 2 cycles; PACK 3; STEP 2+2*iter.
//  - STEP with iter==0: S_IDLE -> S_DONE directly, with no loadA and no write.
//  - A is loaded once per STEP command. If src==dst, A keeps the pre-command value.
//  - N is read in S_STEP only. It is valid there because loadN was asserted in the preceding S_CMP.
//  - In S_IDLE and S_DONE all strobes (w, loadA, loadN) are 0. Rw/Rr/aluop/rsel are 0.
//  - Reset (any state) -> S_IDLE on the next edge. All outputs 0, including err.
//    No datapath write occurs in the cycle after reset is sampled.
//  - Simultaneous start and reset: reset wins and the command is dropped.
// CONFIGURATION
//  DPCTRL_ERR_EN defined:
//   - err sets when start=1 while busy=1, and also on STEP with iter==0.
//   - err is cleared only by reset. It does not affect sequencing.
//  DPCTRL_ERR_EN undefined: err tied 0. No detection logic.
// STRUCTURE
//  - dpctrl_pkg: op_e enum (OP_LOAD..OP_STEP), state_e enum, ALU_SHL/ALU_SHL1/ALU_PACK/ALU_SUBH
//    localparams, RSEL_IN/RSEL_ALU constants.
//  - One sub-module: dpctrl_iter_cnt. It is a loadable down-counter, ITER_W wide, with a zero flag.
//  - All remaining logic lives in datapath_ctrl.
// TESTING (bench instantiates datapath_ctrl + datapath, with checker on strobes)
//  1. LOAD dst=2, in=0x1234 -> w=1, Rw=2, rsel=0 for exactly 1 cycle.
//     done 2 cycles after start; R2=0x1234.
//  2. SHL src=2 dst=3 (R2=0x1234) -> R3=0x2468; done at cycle 2; busy high cycles 1-2.
//  3. PACK src=0 dst=1, R0=0xAB12, R1=0x34CD -> loadA cycle 1, write cycle 2.
//     R1=0x12CD; done at cycle 3.
//  4. STEP src=0 dst=1 iter=2, R0=0x0500, R1=0x0003:
//     - iter 1: N=1 -> R1=0x0007.
//     - iter 2: N=0 -> R1=0x000E.
//     - done at cycle 6.
//  5. Reset asserted in S_CMP of STEP -> next cycle: all outputs 0, state S_IDLE, R1 unchanged.
//     A following LOAD completes normally.
//  6. With DPCTRL_ERR_EN:
//     - start during PACK -> err=1 sticky, PACK result still correct.
//     - STEP iter=0 -> done at cycle 1, err=1, no writes.

Source files
------------

// File: rtl/dpctrl_pkg.sv
// Shared types and encodings for the datapath sequencer: opcodes, FSM states,
// ALU op codes, write-source select, and the strobe bundle decoded per state.
package dpctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHL  = 2'b01,
    OP_PACK = 2'b10,
    OP_STEP = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_LDA,
    S_PACK,
    S_CMP,
    S_STEP,
    S_DONE
  } state_e;

  localparam logic [1:0] ALU_SHL  = 2'b00;
  localparam logic [1:0] ALU_SHL1 = 2'b01;
  localparam logic [1:0] ALU_PACK = 2'b10;
  localparam logic [1:0] ALU_SUBH = 2'b11;

  localparam logic RSEL_IN  = 1'b0;
  localparam logic RSEL_ALU = 1'b1;

  typedef struct packed {
    logic       rsel;
    logic       w;
    logic [1:0] Rw;
    logic [1:0] Rr;
    logic       loadA;
    logic [1:0] aluop;
    logic       loadN;
    logic       busy;
    logic       done;
  } strobes_t;

  // Moore decode; the N-dependent aluop bit in S_STEP is added by the top.
  function automatic strobes_t decodeStrobes(state_e s, op_e op, logic [1:0] dst, logic [1:0] src);
    strobes_t o;
    o = '0;
    o.busy = (s != S_IDLE);
    case (s)
      S_WR: begin
        o.w    = 1'b1;
        o.Rw   = dst;
        o.rsel = (op == OP_SHL) ? RSEL_ALU : RSEL_IN;
        o.Rr   = (op == OP_SHL) ? src : 2'b00;
        o.aluop = ALU_SHL;
      end
      S_LDA: begin
        o.loadA = 1'b1;
        o.Rr    = src;
      end
      S_PACK: begin
        o.Rr    = dst;
        o.aluop = ALU_PACK;
        o.rsel  = RSEL_ALU;
        o.w     = 1'b1;
        o.Rw    = dst;
      end
      S_CMP: begin
        o.Rr    = dst;
        o.aluop = ALU_SUBH;
        o.loadN = 1'b1;
      end
      S_STEP: begin
        o.Rr    = dst;
        o.Rw    = dst;
        o.rsel  = RSEL_ALU;
        o.w     = 1'b1;
        o.aluop = ALU_SHL;
      end
      S_DONE:  o.done = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/dpctrl_if.sv
// Command handshake plus datapath strobe bundle between a command source,
// the sequencer (slave side) and the register-file/ALU datapath.
interface dpctrl_if #(parameter int ITER_W = 4) ();
  logic              start;
  logic [1:0]        op;
  logic [1:0]        dst;
  logic [1:0]        src;
  logic [ITER_W-1:0] iter;
  logic              N;
  logic              rsel;
  logic              w;
  logic [1:0]        Rw;
  logic [1:0]        Rr;
  logic              loadA;
  logic [1:0]        aluop;
  logic              loadN;
  logic              busy;
  logic              done;
  logic              err;

  modport slave (
    input  start, op, dst, src, iter, N,
    output rsel, w, Rw, Rr, loadA, aluop, loadN, busy, done, err
  );

  modport master (
    output start, op, dst, src, iter, N,
    input  rsel, w, Rw, Rr, loadA, aluop, loadN, busy, done, err
  );
endinterface

// File: rtl/dpctrl_iter_cnt.sv
// Loadable down-counter for STEP repeats; saturates at zero and flags it.
module dpctrl_iter_cnt #(
  parameter int ITER_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              dec,
  input  logic [ITER_W-1:0] loadVal,
  output logic [ITER_W-1:0] count,
  output logic              zero
);

  assign zero = (count == '0);

  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= loadVal;
    else if (dec && !zero)
      count <= count - 1'b1;
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Sequencer driving the 4x16 register-file/ALU datapath from LOAD/SHL/PACK/STEP commands.
// Define DPCTRL_ERR_EN to enable the sticky protocol-error flag (otherwise err is tied 0).
module datapath_ctrl
  import dpctrl_pkg::*;
#(
  parameter int ITER_W = 4
) (
  input logic     clk,
  input logic     reset,
  dpctrl_if.slave bus
);

  state_e            state, stateNext;
  op_e               opReg, opNext;
  logic [1:0]        dstReg, dstNext;
  logic [1:0]        srcReg, srcNext;
  strobes_t          outReg;
  logic              cntLoad;
  logic              cntDec;
  logic              cntZero;
  logic              lastIter;
  logic [ITER_W-1:0] cnt;

  dpctrl_iter_cnt #(.ITER_W(ITER_W)) iterCnt (
    .clk    (clk),
    .reset  (reset),
    .load   (cntLoad),
    .dec    (cntDec),
    .loadVal(bus.iter),
    .count  (cnt),
    .zero   (cntZero)
  );

  // The step that brings the counter to zero is the last one.
  assign lastIter = cntZero || (cnt == ITER_W'(1));
  assign cntDec   = (state == S_STEP);

  always_comb begin
    stateNext = state;
    opNext    = opReg;
    dstNext   = dstReg;
    srcNext   = srcReg;
    cntLoad   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          opNext  = op_e'(bus.op);
          dstNext = bus.dst;
          srcNext = bus.src;
          cntLoad = 1'b1;
          case (op_e'(bus.op))
            OP_LOAD, OP_SHL: stateNext = S_WR;
            OP_PACK:         stateNext = S_LDA;
            default:         stateNext = (bus.iter == '0) ? S_DONE : S_LDA;
          endcase
        end
      end
      S_WR, S_PACK: stateNext = S_DONE;
      S_LDA:        stateNext = (opReg == OP_PACK) ? S_PACK : S_CMP;
      S_CMP:        stateNext = S_STEP;
      S_STEP:       stateNext = lastIter ? S_DONE : S_CMP;
      S_DONE:       stateNext = S_IDLE;
      default:      stateNext = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      opReg  <= OP_LOAD;
      dstReg <= 2'b00;
      srcReg <= 2'b00;
      outReg <= '0;
    end else begin
      state  <= stateNext;
      opReg  <= opNext;
      dstReg <= dstNext;
      srcReg <= srcNext;
      outReg <= decodeStrobes(stateNext, opNext, dstNext, srcNext);
    end
  end

  assign bus.rsel  = outReg.rsel;
  assign bus.w     = outReg.w;
  assign bus.Rw    = outReg.Rw;
  assign bus.Rr    = outReg.Rr;
  assign bus.loadA = outReg.loadA;
  assign bus.loadN = outReg.loadN;
  assign bus.busy  = outReg.busy;
  assign bus.done  = outReg.done;
  // N is only captured by the datapath at the edge entering S_STEP, so it is folded in here.
  assign bus.aluop = outReg.aluop | {1'b0, (state == S_STEP) && bus.N};

`ifdef DPCTRL_ERR_EN
  logic errReg;

  always_ff @(posedge clk) begin
    if (reset)
      errReg <= 1'b0;
    else if (bus.start && (outReg.busy ||
             (op_e'(bus.op) == OP_STEP && bus.iter == '0)))
      errReg <= 1'b1;
  end

  assign bus.err = errReg;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl: a behavioural 4x16 datapath plus a command-level reference
// model of register contents, latency, write counts and the error flag.
module tb_datapath_ctrl;
  import dpctrl_pkg::*;

`ifdef DPCTRL_ERR_EN
  localparam bit ErrEn = 1'b1;
`else
  localparam bit ErrEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] dataIn = 16'h0;
  logic [15:0] regs [4];
  logic [15:0] aReg = 16'h0;
  logic        nFlag = 1'b0;
  logic [15:0] aluRes;
  logic [15:0] rOp;
  logic [15:0] modelR [4];
  bit          expErr = 1'b0;
  int          testsRun = 0;
  int          testsFailed = 0;

  dpctrl_if #(.ITER_W(4)) bus ();

  datapath_ctrl #(.ITER_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Behavioural datapath that the sequencer's strobes drive.
  assign bus.N = nFlag;
  always_comb begin
    rOp = regs[bus.Rr];
    case (bus.aluop)
      2'b00:   aluRes = rOp << 1;
      2'b01:   aluRes = (rOp << 1) | 16'h1;
      2'b10:   aluRes = {aReg[7:0], rOp[7:0]};
      default: aluRes = {8'h00, aReg[15:8]} - rOp;
    endcase
  end

  always @(posedge clk) begin
    if (bus.w)     regs[bus.Rw] <= bus.rsel ? aluRes : dataIn;
    if (bus.loadA) aReg <= regs[bus.Rr];
    if (bus.loadN) nFlag <= ~aluRes[15];
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return {20'h0, bus.busy, bus.done, bus.err, bus.w, bus.loadA, bus.loadN,
            bus.rsel, bus.Rw, bus.Rr, bus.aluop};
  endfunction

  // Runs one command, updating the reference model and checking timing, writes and registers.
  task automatic applyStimulus(input op_e op, input logic [1:0] dst, input logic [1:0] src,
                               input logic [3:0] it, input logic [15:0] din, input bit pokeStart);
    int expLat, expWrites, lat, writes, busyLow;
    logic [1:0]  lastRw;
    logic [15:0] a, diff;
    bit seenDone;
    case (op)
      OP_LOAD: begin modelR[dst] = din; expLat = 2; expWrites = 1; end
      OP_SHL:  begin modelR[dst] = modelR[src] << 1; expLat = 2; expWrites = 1; end
      OP_PACK: begin modelR[dst] = {modelR[src][7:0], modelR[dst][7:0]}; expLat = 3; expWrites = 1; end
      default: begin
        a = modelR[src];
        for (int k = 0; k < int'(it); k++) begin
          diff = {8'h00, a[15:8]} - modelR[dst];
          modelR[dst] = {modelR[dst][14:0], ~diff[15]};
        end
        expLat = (it == 4'd0) ? 1 : 2 + 2 * int'(it);
        expWrites = int'(it);
        if (it == 4'd0 && ErrEn) expErr = 1'b1;
      end
    endcase
    if (pokeStart && ErrEn) expErr = 1'b1;

    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.dst = dst; bus.src = src; bus.iter = it; dataIn = din;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0; writes = 0; busyLow = 0; seenDone = 1'b0; lastRw = 2'b00;
    for (int c = 1; c <= 40 && !seenDone; c++) begin
      @(negedge clk);
      if (bus.w) begin writes++; lastRw = bus.Rw; end
      if (!bus.busy) busyLow++;
      if (bus.done) begin seenDone = 1'b1; lat = c; end
      if (pokeStart && c == 1) begin bus.start = 1'b1; bus.op = OP_LOAD; end
      if (pokeStart && c == 2) bus.start = 1'b0;
    end
    checkOutput($sformatf("latency op%0d", op), lat, expLat);
    checkOutput($sformatf("writes op%0d", op), writes, expWrites);
    checkOutput("busyDuringCmd", busyLow, 0);
    if (expWrites > 0) checkOutput("writeIndex", lastRw, dst);
    @(negedge clk);
    checkOutput("idleAfterDone", {bus.busy, bus.done, bus.w, bus.loadA, bus.loadN, bus.rsel,
                                  bus.Rw, bus.Rr, bus.aluop}, 32'h0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("R%0d", i), regs[i], modelR[i]);
  endtask

  initial begin
    bus.start = 1'b0; bus.op = 2'b00; bus.dst = 2'b00; bus.src = 2'b00; bus.iter = 4'd0;
    for (int i = 0; i < 4; i++) begin regs[i] = 16'h0; modelR[i] = 16'h0; end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("resetOutputs", allOutputs(), 32'h0);

    applyStimulus(OP_LOAD, 2'd2, 2'd0, 4'd0, 16'h1234, 1'b0);
    checkOutput("loadR2", regs[2], 16'h1234);
    applyStimulus(OP_SHL, 2'd3, 2'd2, 4'd0, 16'h0, 1'b0);
    checkOutput("shlR3", regs[3], 16'h2468);

    applyStimulus(OP_LOAD, 2'd0, 2'd0, 4'd0, 16'hAB12, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 4'd0, 16'h34CD, 1'b0);
    applyStimulus(OP_PACK, 2'd1, 2'd0, 4'd0, 16'h0, 1'b0);
    checkOutput("packR1", regs[1], 16'h12CD);

    applyStimulus(OP_LOAD, 2'd0, 2'd0, 4'd0, 16'h0500, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 4'd0, 16'h0003, 1'b0);
    applyStimulus(OP_STEP, 2'd1, 2'd0, 4'd2, 16'h0, 1'b0);
    checkOutput("stepR1", regs[1], 16'h000E);

    // Start while busy with a PACK: must be ignored, flagged only when err is enabled.
    applyStimulus(OP_LOAD, 2'd0, 2'd0, 4'd0, 16'hAB12, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 4'd0, 16'h34CD, 1'b0);
    applyStimulus(OP_PACK, 2'd1, 2'd0, 4'd0, 16'h0, 1'b1);
    checkOutput("packR1Poked", regs[1], 16'h12CD);
    checkOutput("errAfterPoke", bus.err, expErr);

    // Reset during S_CMP of a STEP aborts it without touching R1.
    applyStimulus(OP_LOAD, 2'd0, 2'd0, 4'd0, 16'h0500, 1'b0);
    applyStimulus(OP_LOAD, 2'd1, 2'd0, 4'd0, 16'h0003, 1'b0);
    @(negedge clk);
    bus.start = 1'b1; bus.op = OP_STEP; bus.dst = 2'd1; bus.src = 2'd0; bus.iter = 4'd2;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("cmpLoadN", {bus.loadN, bus.w, bus.aluop}, {1'b1, 1'b0, ALU_SUBH});
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    expErr = 1'b0;
    @(negedge clk);
    checkOutput("abortOutputs", allOutputs(), 32'h0);
    checkOutput("abortR1", regs[1], 16'h0003);
    applyStimulus(OP_LOAD, 2'd3, 2'd0, 4'd0, 16'h5A5A, 1'b0);

    applyStimulus(OP_STEP, 2'd2, 2'd1, 4'd0, 16'h0, 1'b0);
    checkOutput("errStepZero", bus.err, expErr);

    for (int n = 0; n < 40; n++)
      applyStimulus(op_e'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    4'($urandom_range(0, 4)), 16'($urandom), 1'b0);
    checkOutput("errFinal", bus.err, expErr);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
